// File: rtl/mce_util_pkg.sv
// Shared helpers for the KEM-core support blocks: ceiling log2 and the loader FSM encoding.
package mce_util_pkg;

  function automatic int unsigned CLOG2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } load_state_e;

endpackage

// File: rtl/stream_loader_profiler_skid.sv
// Two-entry valid/ready buffer with a registered head entry; reports whether
// another read may be launched given the reads still in flight.
module stream_skid2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pending,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full_or_pending,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;
  logic [2:0]       load_c;

  always_comb begin
    pop    = (occ_q != 2'd0) && pop_ready;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_data;
        else               ent1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end else begin
          ent0_d = push_data;
        end
      end
      default: ;
    endcase
    // A pop this cycle frees a slot in time for a read launched now, so it is credited.
    load_c = 3'(occ_q) + 3'(pending) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign dout            = ent0_q;
  assign dout_valid      = (occ_q != 2'd0);
  assign occupancy       = occ_q;
  assign full_or_pending = (load_c >= 3'd2);

endmodule

// File: rtl/stream_loader_profiler.sv
// Streams len words from a 1-cycle-latency memory into a valid/ready consumer and
// measures start-to-done latency on NUM_EV independent event channels.
module stream_loader_profiler
  import mce_util_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned NUM_EV = 3,
  parameter  int unsigned CNT_W  = 32,
  localparam int unsigned ADDR_W = CLOG2(DEPTH),
  localparam int unsigned LEN_W  = CLOG2(DEPTH + 1),
  localparam int unsigned SEL_W  = CLOG2(NUM_EV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              load_done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_q,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic [NUM_EV-1:0] ev_start,
  input  logic [NUM_EV-1:0] ev_done,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt_out,
  output logic [NUM_EV-1:0] cnt_valid,
  output logic [NUM_EV-1:0] overflow
);

  load_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_eff_q, len_eff_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [LEN_W-1:0] len_clamp;
  logic             pop, rd_go;
  logic             full_or_pending;
  logic [1:0]       occupancy;

  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk             (clk),
    .rst             (rst),
    .push            (rd_pend_q),
    .push_data       (mem_q),
    .pending         (rd_pend_q),
    .pop_ready       (dout_ready),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .full_or_pending (full_or_pending),
    .occupancy       (occupancy)
  );

  always_comb begin
    len_clamp = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    pop       = (occupancy != 2'd0) && dout_ready;
    rd_go     = (state_q == ST_LOAD) && (rd_cnt_q < len_eff_q) && !full_or_pending;
    state_d   = state_q;
    len_eff_d = len_eff_q;
    rd_cnt_d  = rd_cnt_q;
    acc_cnt_d = acc_cnt_q;
    rd_pend_d = rd_go;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_eff_d = len_clamp;
          rd_cnt_d  = '0;
          acc_cnt_d = '0;
          state_d   = (len_clamp == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rd_go) rd_cnt_d  = rd_cnt_q + LEN_W'(1);
        if (pop)   acc_cnt_d = acc_cnt_q + LEN_W'(1);
        if (acc_cnt_d == len_eff_q) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_eff_q <= '0;
      rd_cnt_q  <= '0;
      acc_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_eff_q <= len_eff_d;
      rd_cnt_q  <= rd_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign busy      = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_FINISH);
  assign mem_rd    = rd_go;
  assign mem_addr  = rd_cnt_q[ADDR_W-1:0];

  logic [NUM_EV-1:0] st_prev_q, dn_prev_q;
  logic [CNT_W-1:0]  cnt_all [NUM_EV];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_prev_q <= '0;
      dn_prev_q <= '0;
    end else begin
      st_prev_q <= ev_start;
      dn_prev_q <= ev_done;
    end
  end

  for (genvar i = 0; i < NUM_EV; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d, vld_q, vld_d, ovf_q, ovf_d;
    logic             st_edge, dn_edge;

    // The done-edge cycle still counts, so the frozen value is D - S.
    always_comb begin
      st_edge = ev_start[i] & ~st_prev_q[i];
      dn_edge = ev_done[i] & ~dn_prev_q[i];
      cnt_d   = cnt_q;
      armed_d = armed_q;
      vld_d   = vld_q;
      ovf_d   = ovf_q;
      if (st_edge) begin
        cnt_d   = '0;
        armed_d = 1'b1;
        vld_d   = 1'b0;
        ovf_d   = 1'b0;
      end else if (armed_q) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == '1) ovf_d = 1'b1;
        if (dn_edge) begin
          armed_d = 1'b0;
          vld_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
        vld_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        vld_q   <= vld_d;
        ovf_q   <= ovf_d;
      end
    end

    assign cnt_all[i]   = cnt_q;
    assign cnt_valid[i] = vld_q;
    assign overflow[i]  = ovf_q;
  end

  always_comb begin
    cnt_out = '0;
    for (int unsigned k = 0; k < NUM_EV; k++) begin
      if (cnt_sel == SEL_W'(k)) cnt_out = cnt_all[k];
    end
  end

endmodule

// File: tb/tb_stream_loader_profiler.sv
// Directed bench for stream_loader_profiler: load timing, backpressure, length edge
// cases, profiler counts, saturation on a narrow-counter instance, reset mid-load.
module tb_stream_loader_profiler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, load_done, mem_rd, dout_valid, dout_ready;
  logic [4:0]  len;
  logic [3:0]  mem_addr;
  logic [31:0] mem_q, dout, cnt_out;
  logic [2:0]  ev_start, ev_done, cnt_valid, overflow;
  logic [1:0]  cnt_sel;

  logic [2:0]  sev_start, sev_done, scnt_valid, sovf;
  logic [1:0]  scnt_sel;
  logic [3:0]  scnt_out, s_addr;
  logic        s_busy, s_done, s_rd, s_dvalid;
  logic [31:0] s_dout;

  stream_loader_profiler #(.WIDTH(32), .DEPTH(16), .NUM_EV(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .load_done(load_done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .ev_start(ev_start),
    .ev_done(ev_done), .cnt_sel(cnt_sel), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
    .overflow(overflow)
  );

  stream_loader_profiler #(.WIDTH(32), .DEPTH(16), .NUM_EV(3), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(1'b0), .len(5'd0), .busy(s_busy), .load_done(s_done),
    .mem_rd(s_rd), .mem_addr(s_addr), .mem_q(32'd0), .dout(s_dout),
    .dout_valid(s_dvalid), .dout_ready(1'b1), .ev_start(sev_start),
    .ev_done(sev_done), .cnt_sel(scnt_sel), .cnt_out(scnt_out), .cnt_valid(scnt_valid),
    .overflow(sovf)
  );

  logic [31:0] mem [16];
  initial begin
    mem_q = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
  end
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_at(input int c);
    if (c >= 8 && c <= 12) return 1'b0;
    return (c % 3 == 0);
  endfunction

  int done_cyc, first_cyc, nrd, nacc, seq_err, addr_err, stall_err, max_out, busy_cyc;

  // Cycle 0 is the cycle start is driven; samples are taken mid-cycle.
  task automatic run_load(input logic [4:0] l, input bit bp, input bit poke);
    logic [31:0] held;
    bit          stalled;
    done_cyc = -1; first_cyc = -1; nrd = 0; nacc = 0; seq_err = 0;
    addr_err = 0; stall_err = 0; max_out = 0; busy_cyc = 0;
    stalled = 1'b0; held = '0;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (poke && (c == 4 || c == 9));
      len        = (c == 0) ? l : 5'd3;
      dout_ready = bp ? ready_at(c) : 1'b1;
      #3;
      if (mem_rd) begin
        if (mem_addr !== 4'(nrd)) addr_err++;
        nrd++;
      end
      if (stalled && (!dout_valid || dout !== held)) stall_err++;
      if (dout_valid && dout_ready) begin
        if (dout !== 32'h1000 + nacc) seq_err++;
        if (first_cyc < 0) first_cyc = c;
        nacc++;
      end
      if (nrd - nacc > max_out) max_out = nrd - nacc;
      stalled = dout_valid && !dout_ready;
      held    = dout;
      if (busy) busy_cyc++;
      if (load_done) done_cyc = c;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; dout_ready = 1'b1;
    ev_start = '0; ev_done = '0; cnt_sel = '0;
    sev_start = '0; sev_done = '0; scnt_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("rst_load_outs", {busy, load_done, mem_rd, mem_addr, dout_valid, dout}, '0);
    chk("rst_prof_outs", {cnt_valid, overflow, cnt_out}, '0);
    chk("rst_small_idle", {s_busy, s_done, s_rd, s_dvalid, s_addr, s_dout, scnt_out, scnt_valid, sovf}, '0);

    run_load(5'd16, 1'b0, 1'b0);
    chk("basic_done_cyc", done_cyc, 19);
    chk("basic_first_cyc", first_cyc, 3);
    chk("basic_reads", nrd, 16);
    chk("basic_words", nacc, 16);
    chk("basic_seq_err", seq_err, 0);
    chk("basic_addr_err", addr_err, 0);
    chk("basic_busy_cyc", busy_cyc, 18);
    chk("basic_outstanding", max_out <= 2, 1);

    run_load(5'd0, 1'b0, 1'b0);
    chk("len0_done_cyc", done_cyc, 1);
    chk("len0_reads", nrd, 0);
    chk("len0_busy_cyc", busy_cyc, 0);

    run_load(5'd20, 1'b0, 1'b0);
    chk("len20_words", nacc, 16);
    chk("len20_reads", nrd, 16);
    chk("len20_done_cyc", done_cyc, 19);
    chk("len20_seq_err", seq_err, 0);

    run_load(5'd16, 1'b0, 1'b1);
    chk("poke_words", nacc, 16);
    chk("poke_done_cyc", done_cyc, 19);
    chk("poke_seq_err", seq_err, 0);

    run_load(5'd16, 1'b1, 1'b0);
    chk("bp_words", nacc, 16);
    chk("bp_reads", nrd, 16);
    chk("bp_seq_err", seq_err, 0);
    chk("bp_addr_err", addr_err, 0);
    chk("bp_stall_err", stall_err, 0);
    chk("bp_outstanding", max_out <= 2, 1);
    chk("bp_done_seen", done_cyc > 0, 1);
    dout_ready = 1'b1;

    cnt_sel = 2'd0;
    for (int c = 0; c <= 101; c++) begin
      @(posedge clk); #1;
      if (c == 0)   ev_start[0] = 1'b1;
      if (c == 40)  ev_done[1]  = 1'b1;
      if (c == 100) ev_done[0]  = 1'b1;
      #3;
      if (c == 50) begin
        chk("prof_live_cnt", cnt_out, 49);
        chk("prof_mid_valid", cnt_valid[0], 0);
      end
      if (c == 101) begin
        chk("prof_cnt", cnt_out, 100);
        chk("prof_valid", cnt_valid[0], 1);
        chk("prof_stray_valid", cnt_valid[1], 0);
      end
    end
    repeat (5) @(posedge clk);
    #4 chk("prof_frozen", cnt_out, 100);
    cnt_sel = 2'd1;
    #1 chk("prof_ch1_cnt", cnt_out, 0);

    cnt_sel = 2'd2;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin ev_start[2] = 1'b1; ev_done[2] = 1'b1; end
      if (c == 6) ev_done[2] = 1'b0;
      if (c == 8) ev_done[2] = 1'b1;
      #3;
      if (c == 1) begin
        chk("simul_cnt", cnt_out, 0);
        chk("simul_valid", cnt_valid[2], 0);
      end
      if (c == 6) chk("simul_armed_cnt", cnt_out, 5);
      if (c == 9) begin
        chk("simul_done_cnt", cnt_out, 8);
        chk("simul_done_valid", cnt_valid[2], 1);
      end
    end

    scnt_sel = 2'd0;
    for (int c = 0; c <= 23; c++) begin
      @(posedge clk); #1;
      if (c == 0)  sev_start[0] = 1'b1;
      if (c == 20) sev_done[0]  = 1'b1;
      if (c == 22) sev_start[0] = 1'b0;
      if (c == 23) sev_start[0] = 1'b1;
      #3;
      if (c == 15) begin
        chk("ovf_pre_cnt", scnt_out, 14);
        chk("ovf_pre_flag", sovf[0], 0);
      end
      if (c == 16) chk("ovf_hit_flag", sovf[0], 1);
      if (c == 21) begin
        chk("ovf_cnt", scnt_out, 15);
        chk("ovf_flag", sovf[0], 1);
        chk("ovf_valid", scnt_valid[0], 1);
      end
    end
    @(posedge clk); #4;
    chk("ovf_restart", {scnt_out, sovf[0], scnt_valid[0]}, 0);

    ev_start = '0; ev_done = '0; sev_start = '0; sev_done = '0;
    cnt_sel = 2'd0;
    repeat (2) @(posedge clk);

    @(posedge clk); #1;
    start = 1'b1; len = 5'd16; dout_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #3 chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("mid_rst_load_outs", {busy, load_done, mem_rd, mem_addr, dout_valid, dout}, '0);
    chk("mid_rst_prof_outs", {cnt_valid, overflow, cnt_out}, '0);

    run_load(5'd16, 1'b0, 1'b0);
    chk("post_rst_words", nacc, 16);
    chk("post_rst_seq_err", seq_err, 0);
    chk("post_rst_addr_err", addr_err, 0);
    chk("post_rst_done_cyc", done_cyc, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
